// File: rtl/sl_adc_pkg.sv
// Shared definitions for the hydrophone ADC to SPI transmit path:
// channel/sample sizing, serializer word layout and scheduler states.
package sl_adc_pkg;

    localparam int NUM_CH     = 4;
    localparam int SAMPLE_W   = 12;

    // Serializer word layout
    localparam int WORD_W     = 16;
    localparam int CH_LSB     = 14;
    localparam int CH_FIELD_W = 2;
    localparam int OVF_BIT    = 13;
    localparam int RSVD_BIT   = 12;
    localparam int SAMPLE_LSB = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/spi_tx_scheduler_if.sv
// Sample-in / word-out bundle of the transmit scheduler. The master side is
// the scheduler itself; the slave side is the ADC front end plus serializer.
interface spi_tx_scheduler_if #(
    parameter int NUM_CH   = sl_adc_pkg::NUM_CH,
    parameter int SAMPLE_W = sl_adc_pkg::SAMPLE_W
);
    import sl_adc_pkg::*;

    logic [NUM_CH-1:0]          ch_valid;
    logic [NUM_CH*SAMPLE_W-1:0] ch_data;
    logic                       ready_for_data;
    logic                       Indata_valid;
    logic [WORD_W-1:0]          unprocessed_MISO;

    modport master (
        input  ch_valid,
        input  ch_data,
        input  ready_for_data,
        output Indata_valid,
        output unprocessed_MISO
    );

    modport slave (
        output ch_valid,
        output ch_data,
        output ready_for_data,
        input  Indata_valid,
        input  unprocessed_MISO
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting index at or after ptr, wrapping
// modulo N. Purely combinational.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        dbl = {req, req};
        rot = N'(dbl >> ptr);
        off = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDX_W'(k);
                any = 1'b1;
            end
        end
        sum   = {1'b0, ptr} + {1'b0, off};
        grant = (int'(sum) >= N) ? IDX_W'(int'(sum) - N) : IDX_W'(sum);
    end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Collects one-shot ADC samples per channel and feeds them one word at a
// time into an SPI serializer, round-robin across channels, with overwrite
// tracking and a retry when the serializer never acknowledges a word.
module spi_tx_scheduler #(
    parameter int NUM_CH      = sl_adc_pkg::NUM_CH,
    parameter int SAMPLE_W    = sl_adc_pkg::SAMPLE_W,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               enable,
    spi_tx_scheduler_if.master bus,
    output logic               busy,
    output logic [7:0]         overflow_count
);
    import sl_adc_pkg::*;

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t              state_reg;
    logic [CH_W-1:0]     ptr_reg;
    logic [CH_W-1:0]     ptr_next;
    logic [CH_W-1:0]     gnt_reg;
    logic [TMR_W-1:0]    timer_reg;
    logic [WORD_W-1:0]   word_reg;
    logic [WORD_W-1:0]   word_next;
    logic                valid_reg;
    logic                busy_reg;
    logic [7:0]          ovf_cnt_reg;
    logic [7:0]          ovf_cnt_next;

    logic [NUM_CH-1:0]   pend_vec;
    logic [NUM_CH-1:0]   ovf_vec;
    logic [NUM_CH-1:0]   ovf_event;
    logic [SAMPLE_W-1:0] hold_arr [NUM_CH];

    logic [CH_W-1:0]     grant_idx;
    logic                grant_any;
    logic                grant_fire;
    logic                ack_timeout;

    rr_arbiter #(
        .N     (NUM_CH),
        .IDX_W (CH_W)
    ) u_arb (
        .req   (pend_vec),
        .ptr   (ptr_reg),
        .grant (grant_idx),
        .any   (grant_any)
    );

    // A grant is only taken from IDLE with the serializer free
    assign grant_fire  = (state_reg == IDLE) && enable && bus.ready_for_data && grant_any;
    // Serializer never dropped ready within the allowed window
    assign ack_timeout = (state_reg == WAIT_ACK) && bus.ready_for_data &&
                         (timer_reg == TMR_W'(ACK_TIMEOUT - 1));

    // Per-channel holding register with pending / overwritten flags
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic                pend_reg;
            logic                ovf_reg;
            logic [SAMPLE_W-1:0] hold_reg;
            logic                granted;
            logic                requeue;
            logic                strobe;

            assign strobe        = bus.ch_valid[gi];
            assign granted       = grant_fire && (grant_idx == CH_W'(gi));
            assign requeue       = ack_timeout && (gnt_reg == CH_W'(gi));
            // Overwrite of an unsent sample; a strobe landing on the grant cycle is not one
            assign ovf_event[gi] = strobe && pend_reg && !granted;
            assign pend_vec[gi]  = pend_reg;
            assign ovf_vec[gi]   = ovf_reg;
            assign hold_arr[gi]  = hold_reg;

            // Capture, overwrite, grant-clear and timeout-requeue of this channel
            always_ff @(posedge sclk or negedge rst) begin
                if (!rst) begin
                    pend_reg <= 1'b0;
                    ovf_reg  <= 1'b0;
                    hold_reg <= '0;
                end else if (strobe) begin
                    hold_reg <= bus.ch_data[gi*SAMPLE_W +: SAMPLE_W];
                    pend_reg <= 1'b1;
                    if (granted) begin
                        ovf_reg <= 1'b0;
                    end else if (pend_reg) begin
                        ovf_reg <= 1'b1;
                    end
                end else if (granted) begin
                    pend_reg <= 1'b0;
                    ovf_reg  <= 1'b0;
                end else if (requeue) begin
                    pend_reg <= 1'b1;
                end
            end
        end
    endgenerate

    // Word for the channel being granted this cycle (old sample, old ovf flag)
    always_comb begin
        word_next                              = '0;
        word_next[CH_LSB +: CH_FIELD_W]        = CH_FIELD_W'(grant_idx);
        word_next[OVF_BIT]                     = ovf_vec[grant_idx];
        word_next[RSVD_BIT]                    = 1'b0;
        word_next[SAMPLE_LSB +: SAMPLE_W]      = hold_arr[grant_idx];
    end

    // Pointer moves to the slot after the granted channel
    always_comb begin
        ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end

    // Several channels may overwrite in one cycle; add each, sticking at 255
    always_comb begin
        ovf_cnt_next = ovf_cnt_reg;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ovf_event[i]) begin
                ovf_cnt_next = sat_inc8(ovf_cnt_next);
            end
        end
    end

    // Overflow counter
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            ovf_cnt_reg <= '0;
        end else begin
            ovf_cnt_reg <= ovf_cnt_next;
        end
    end

    // Transaction sequencer with registered strobe, word and busy
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            timer_reg <= '0;
            word_reg  <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_fire) begin
                        state_reg <= ISSUE;
                        ptr_reg   <= ptr_next;
                        gnt_reg   <= grant_idx;
                        word_reg  <= word_next;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT_ACK;
                    timer_reg <= '0;
                end
                WAIT_ACK: begin
                    if (!bus.ready_for_data) begin
                        state_reg <= WAIT_DONE;
                    end else if (ack_timeout) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (bus.ready_for_data) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Indata_valid     = valid_reg;
    assign bus.unprocessed_MISO = word_reg;
    assign busy                 = busy_reg;
    assign overflow_count       = ovf_cnt_reg;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler with a small serializer model that
// records every launched word and acknowledges after a fixed delay.
module tb_spi_tx_scheduler;

    localparam int NUM_CH      = 4;
    localparam int SAMPLE_W    = 12;
    localparam int ACK_TIMEOUT = 8;

    logic       sclk   = 1'b0;
    logic       rst    = 1'b0;
    logic       enable = 1'b0;
    logic       busy;
    logic [7:0] overflow_count;

    spi_tx_scheduler_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) bus ();

    spi_tx_scheduler #(
        .NUM_CH      (NUM_CH),
        .SAMPLE_W    (SAMPLE_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .sclk           (sclk),
        .rst            (rst),
        .enable         (enable),
        .bus            (bus),
        .busy           (busy),
        .overflow_count (overflow_count)
    );

    always #5 sclk = ~sclk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] words [$];
    int          ser_mode     = 0;   // 0: acks normally, 1: ready stuck high
    int          ser_busy     = 4;   // cycles ready stays low after the ack

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [15:0] get_word(input int idx);
        if (idx < words.size()) return words[idx];
        return 16'hDEAD;
    endfunction

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (words.size() < target && n < budget) begin
            @(negedge sclk);
            n++;
        end
        if (words.size() < target) check("word wait timeout", words.size(), target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge sclk);
            n++;
        end
        if (busy !== 1'b0) check("idle wait timeout", busy, 0);
    endtask

    task automatic strobe(input int ch, input logic [11:0] data);
        @(negedge sclk);
        bus.ch_valid                   = '0;
        bus.ch_valid[ch]               = 1'b1;
        bus.ch_data[ch*SAMPLE_W +: SAMPLE_W] = data;
        @(negedge sclk);
        bus.ch_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge sclk);
        rst = 1'b0;
        repeat (2) @(negedge sclk);
        rst = 1'b1;
    endtask

    // Serializer model
    initial begin
        bus.ready_for_data = 1'b1;
        forever begin
            @(posedge sclk);
            #1;
            if (bus.Indata_valid === 1'b1) begin
                words.push_back(bus.unprocessed_MISO);
                $display("[TB] serializer took word 0x%04h", bus.unprocessed_MISO);
                if (ser_mode == 0) begin
                    repeat (2) @(posedge sclk);
                    #1 bus.ready_for_data = 1'b0;
                    repeat (ser_busy) @(posedge sclk);
                    #1 bus.ready_for_data = 1'b1;
                end
            end
        end
    end

    logic [15:0] exp4 [4] = '{16'h0001, 16'h4002, 16'h8003, 16'hC004};

    initial begin
        int base;
        int n;
        bus.ch_valid = '0;
        bus.ch_data  = '0;

        // Reset state
        repeat (3) @(negedge sclk);
        check("rst Indata_valid", bus.Indata_valid, 0);
        check("rst MISO", bus.unprocessed_MISO, 0);
        check("rst busy", busy, 0);
        check("rst overflow_count", overflow_count, 0);
        rst    = 1'b1;
        enable = 1'b1;

        // Single sample on ch2
        strobe(2, 12'hABC);
        wait_words(1, 20);
        check("t1 word", get_word(0), 16'h8ABC);
        wait_idle(40);
        check("t1 busy", busy, 0);
        check("t1 ready at idle", bus.ready_for_data, 1);
        check("t1 MISO held", bus.unprocessed_MISO, 16'h8ABC);
        repeat (10) @(negedge sclk);
        check("t1 pulse count", words.size(), 1);

        // All four channels in one cycle
        do_reset();
        base = words.size();
        @(negedge sclk);
        bus.ch_valid = 4'hF;
        bus.ch_data  = {12'h004, 12'h003, 12'h002, 12'h001};
        @(negedge sclk);
        bus.ch_valid = '0;
        wait_words(base + 4, 120);
        for (int k = 0; k < 4; k++) check($sformatf("t2 word%0d", k), get_word(base + k), exp4[k]);
        check("t2 overflow_count", overflow_count, 0);
        wait_idle(40);

        // Overwrite while the serializer is busy
        base = words.size();
        strobe(0, 12'h055);
        wait_words(base + 1, 20);
        check("t3 ch0 word", get_word(base), 16'h0055);
        strobe(1, 12'h111);
        strobe(1, 12'h222);
        check("t3 overflow_count", overflow_count, 1);
        wait_words(base + 2, 40);
        check("t3 ch1 word", get_word(base + 1), 16'h6222);
        check("t3 overflow_count kept", overflow_count, 1);
        wait_idle(40);

        // Serializer never drops ready: timeout then reissue
        ser_mode = 1;
        base = words.size();
        strobe(3, 12'h3C3);
        wait_words(base + 1, 20);
        check("t4 first word", get_word(base), 16'hC3C3);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge sclk);
            n++;
        end
        check("t4 cycles to idle", n, ACK_TIMEOUT + 1);
        ser_mode = 0;
        wait_words(base + 2, 20);
        check("t4 reissued word", get_word(base + 1), 16'hC3C3);
        wait_idle(40);
        check("t4 pulse count", words.size(), base + 2);

        // 300 overwrites on ch0 with grants blocked
        do_reset();
        enable = 1'b0;
        base = words.size();
        @(negedge sclk);
        for (int i = 0; i < 255; i++) begin
            bus.ch_valid         = 4'b0001;
            bus.ch_data[11:0]    = 12'(i);
            @(negedge sclk);
        end
        bus.ch_valid = '0;
        check("t5 overflow after 254", overflow_count, 254);
        for (int i = 0; i < 46; i++) begin
            bus.ch_valid         = 4'b0001;
            bus.ch_data[11:0]    = (i == 45) ? 12'h5A5 : 12'(i + 256);
            @(negedge sclk);
        end
        bus.ch_valid = '0;
        check("t5 overflow saturated", overflow_count, 255);
        repeat (5) @(negedge sclk);
        check("t5 no grant while disabled", words.size(), base);
        enable = 1'b1;
        wait_words(base + 1, 20);
        check("t5 ch0 word", get_word(base), 16'h25A5);
        wait_idle(40);

        // Reset during WAIT_DONE
        ser_busy = 12;
        base = words.size();
        strobe(1, 12'h777);
        wait_words(base + 1, 20);
        check("t6 word", get_word(base), 16'h4777);
        n = 0;
        while (bus.ready_for_data === 1'b1 && n < 20) begin
            @(negedge sclk);
            n++;
        end
        @(negedge sclk);
        check("t6 busy before reset", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t6 Indata_valid in reset", bus.Indata_valid, 0);
        check("t6 MISO in reset", bus.unprocessed_MISO, 0);
        check("t6 busy in reset", busy, 0);
        check("t6 overflow in reset", overflow_count, 0);
        @(negedge sclk);
        rst = 1'b1;
        repeat (25) @(negedge sclk);
        check("t6 no pulse after reset", words.size(), base + 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
